// File: rtl/axi_write_burst.sv
// axi_write_burst: AXI4 write master, streams beats into fixed INCR bursts.
// Build macro AXI_WR_TLAST_CHECK_EN: frame check of S_WR_tlast vs wlast.
`timescale 1ns/1ps
module axi_write_burst #(
  parameter int AW_FLIP_BYTE = 0,
  parameter int AW_ADDR_WIDTH = 32,
  parameter int AW_DATA_WIDTH = 64,
  parameter int AW_LIN = 16,
  parameter logic [AW_ADDR_WIDTH-1:0] AW_BASE_ADDR = '0,
  parameter int AW_STRIDE = 4096,
  parameter int AW_REGION = 32'h10000
) (
  input  logic                       S_WR_aclk,
  input  logic                       S_WR_areset,
  input  logic                       i_wr_en,
  output logic                       o_wr_done,
  output logic                       o_wr_err,
  input  logic [AW_DATA_WIDTH-1:0]   S_WR_tdata,
  input  logic                       S_WR_tvalid,
  output logic                       S_WR_tready,
  input  logic                       S_WR_tlast,
  output logic                       m_axi_awid,
  output logic [AW_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic [2:0]                 m_axi_awsize,
  output logic [1:0]                 m_axi_awburst,
  output logic                       m_axi_awlock,
  output logic [3:0]                 m_axi_awcache,
  output logic [2:0]                 m_axi_awprot,
  output logic [3:0]                 m_axi_awqos,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [AW_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AW_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                       m_axi_wlast,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic                       m_axi_bid,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready
);

  localparam int SB = AW_DATA_WIDTH / 8;
  localparam int CW = (AW_LIN > 1) ? $clog2(AW_LIN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(AW_LIN - 1);
  localparam logic [7:0] LEN = 8'(AW_LIN - 1);
  localparam logic [2:0] SIZE = 3'($clog2(SB));
  localparam logic [AW_ADDR_WIDTH-1:0] STEP =
    AW_ADDR_WIDTH'(AW_STRIDE);
  localparam logic [AW_ADDR_WIDTH-1:0] SPAN =
    AW_ADDR_WIDTH'(AW_REGION);
  localparam logic [AW_ADDR_WIDTH-1:0] WRAP_AT =
    AW_BASE_ADDR + SPAN - STEP;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t                     state;
  logic [AW_ADDR_WIDTH-1:0]   addr_buf;
  logic [AW_ADDR_WIDTH-1:0]   addr_next;
  logic [CW-1:0]              beat_cnt;
  logic                       in_data;
  logic                       at_last;
  logic                       w_hs;
  logic                       frame_err;

  // Fixed AW attributes: single ID, INCR, normal non-cacheable bufferable.
  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = LEN;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wstrb   = '1;

  // W channel is a straight pass-through of the stream while in DATA.
  assign in_data      = (state == S_DATA);
  assign at_last      = (beat_cnt == LAST_BEAT);
  assign m_axi_wvalid = in_data && S_WR_tvalid;
  assign S_WR_tready  = in_data && m_axi_wready;
  assign m_axi_wlast  = in_data && at_last;
  assign w_hs         = m_axi_wvalid && m_axi_wready;

  generate
    if (AW_FLIP_BYTE != 0) begin : g_flip
      logic [AW_DATA_WIDTH-1:0] flip_data;
      for (genvar b = 0; b < SB; b++) begin : g_byte
        assign flip_data[8*b +: 8] = S_WR_tdata[8*(SB-1-b) +: 8];
      end
      assign m_axi_wdata = flip_data;
    end else begin : g_pass
      assign m_axi_wdata = S_WR_tdata;
    end
  endgenerate

  // Next ring slot: step by the stride, wrap at the last slot.
  always_comb begin
    addr_next = addr_buf + STEP;
    if (addr_buf >= WRAP_AT) begin
      addr_next = AW_BASE_ADDR;
    end
  end

`ifdef AXI_WR_TLAST_CHECK_EN
  logic unused_ok;
  assign unused_ok = m_axi_bid;

  // Sticky frame error: stream tlast disagreed with our wlast on a beat.
  always_ff @(posedge S_WR_aclk or posedge S_WR_areset) begin
    if (S_WR_areset) begin
      frame_err <= 1'b0;
    end else if (state == S_DONE) begin
      frame_err <= 1'b0;
    end else if (w_hs && (S_WR_tlast != m_axi_wlast)) begin
      frame_err <= 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, S_WR_tlast};
  assign frame_err = 1'b0;
`endif

  // Burst sequencer: AW, W beats, B response, completion pulse.
  always_ff @(posedge S_WR_aclk or posedge S_WR_areset) begin
    if (S_WR_areset) begin
      state         <= S_IDLE;
      addr_buf      <= AW_BASE_ADDR;
      beat_cnt      <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_bready  <= 1'b0;
      o_wr_done     <= 1'b0;
      o_wr_err      <= 1'b0;
    end else begin
      o_wr_done <= 1'b0;
      o_wr_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_wr_en && S_WR_tvalid) begin
            state         <= S_ADDR;
            m_axi_awvalid <= 1'b1;
            m_axi_awaddr  <= addr_buf;
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            state         <= S_DATA;
            m_axi_awvalid <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_hs) begin
            if (at_last) begin
              state        <= S_RESP;
              beat_cnt     <= '0;
              m_axi_bready <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            state        <= S_DONE;
            m_axi_bready <= 1'b0;
            o_wr_done    <= 1'b1;
            o_wr_err     <= (m_axi_bresp != 2'b00) || frame_err;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          addr_buf <= addr_next;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_write_burst.sv
// tb_axi_write_burst: table-driven bursts with a W-data scoreboard
// and an address model; second instance checks byte flipping.
`timescale 1ns/1ps
module tb_axi_write_burst;

`ifdef AXI_WR_TLAST_CHECK_EN
  localparam bit TL_ERR = 1'b1;
`else
  localparam bit TL_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        S_WR_areset;
  logic        i_wr_en;
  logic [63:0] S_WR_tdata;
  logic        S_WR_tvalid;
  logic        S_WR_tlast;
  logic        m_axi_awready;
  logic        m_axi_wready;
  logic        m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;

  logic        o_wr_done, o_wr_err, S_WR_tready;
  logic        m_axi_awid, m_axi_awlock, m_axi_awvalid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot;
  logic [1:0]  m_axi_awburst;
  logic [3:0]  m_axi_awcache, m_axi_awqos;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_bready;

  logic        f_done, f_err, f_tready;
  logic        f_awid, f_awlock, f_awvalid;
  logic [31:0] f_awaddr;
  logic [7:0]  f_awlen;
  logic [2:0]  f_awsize, f_awprot;
  logic [1:0]  f_awburst;
  logic [3:0]  f_awcache, f_awqos;
  logic [63:0] f_wdata;
  logic [7:0]  f_wstrb;
  logic        f_wlast, f_wvalid, f_bready;

  always #5 clk = ~clk;

  axi_write_burst dut (
    .S_WR_aclk(clk), .S_WR_areset(S_WR_areset),
    .i_wr_en(i_wr_en), .o_wr_done(o_wr_done),
    .o_wr_err(o_wr_err), .S_WR_tdata(S_WR_tdata),
    .S_WR_tvalid(S_WR_tvalid), .S_WR_tready(S_WR_tready),
    .S_WR_tlast(S_WR_tlast), .m_axi_awid(m_axi_awid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  axi_write_burst #(.AW_FLIP_BYTE(1)) dut_f (
    .S_WR_aclk(clk), .S_WR_areset(S_WR_areset),
    .i_wr_en(i_wr_en), .o_wr_done(f_done),
    .o_wr_err(f_err), .S_WR_tdata(S_WR_tdata),
    .S_WR_tvalid(S_WR_tvalid), .S_WR_tready(f_tready),
    .S_WR_tlast(S_WR_tlast), .m_axi_awid(f_awid),
    .m_axi_awaddr(f_awaddr), .m_axi_awlen(f_awlen),
    .m_axi_awsize(f_awsize), .m_axi_awburst(f_awburst),
    .m_axi_awlock(f_awlock), .m_axi_awcache(f_awcache),
    .m_axi_awprot(f_awprot), .m_axi_awqos(f_awqos),
    .m_axi_awvalid(f_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb),
    .m_axi_wlast(f_wlast), .m_axi_wvalid(f_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(f_bready)
  );

  typedef struct {
    int          tv_pct;
    int          wr_pct;
    int          aw_pct;
    logic [1:0]  bresp;
    int          tlast_beat;
    logic [63:0] seed;
    bit          drop_en;
    bit          exp_err;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          w_beat = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [31:0] last_awaddr = 32'hFFFF_FFFF;
  bit          exp_err = 1'b0;
  logic [63:0] wq[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] dat(input logic [63:0] s,
                                      input int i);
    return s + 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  function automatic logic [63:0] swap8(input logic [63:0] x);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = x[8*(7-b) +: 8];
    return r;
  endfunction

  // Monitor: scoreboard pops on W handshakes, address model on AW.
  always @(negedge clk) begin
    if (S_WR_areset) begin
      exp_addr = 32'h0;
      w_beat = 0;
    end else begin
      if (m_axi_awvalid && m_axi_awready) begin
        chk("awaddr", 64'(m_axi_awaddr), 64'(exp_addr));
        chk("awlen", 64'(m_axi_awlen), 64'd15);
        chk("awsize", 64'(m_axi_awsize), 64'd3);
        chk("awburst", 64'(m_axi_awburst), 64'd1);
        last_awaddr = m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("wq_nonempty", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) begin
          logic [63:0] e;
          e = wq.pop_front();
          chk("wdata", m_axi_wdata, e);
          chk("wdata_flip", f_wdata, swap8(e));
        end
        chk("wlast", 64'(m_axi_wlast), 64'(w_beat == 15));
        w_beat++;
      end
      if (o_wr_done) begin
        chk("wr_err", 64'(o_wr_err), 64'(exp_err));
        chk("beats", 64'(w_beat), 64'd16);
        w_beat = 0;
        done_cnt++;
        exp_addr = (exp_addr >= 32'hF000) ? 32'h0
                                          : exp_addr + 32'h1000;
      end else begin
        chk("err_alone", 64'(o_wr_err), 64'd0);
      end
    end
  end

  task automatic idle_chk(input string nm);
    chk({nm, "_awvalid"}, 64'(m_axi_awvalid), 64'd0);
    chk({nm, "_wvalid"}, 64'(m_axi_wvalid), 64'd0);
    chk({nm, "_wlast"}, 64'(m_axi_wlast), 64'd0);
    chk({nm, "_bready"}, 64'(m_axi_bready), 64'd0);
    chk({nm, "_tready"}, 64'(S_WR_tready), 64'd0);
    chk({nm, "_done"}, 64'(o_wr_done), 64'd0);
    chk({nm, "_err"}, 64'(o_wr_err), 64'd0);
  endtask

  // Drive one burst's stream; stop_at < 16 leaves it unfinished.
  task automatic run_burst(input vec_t v, input int stop_at);
    int i = 0;
    int g = 0;
    int c0 = done_cnt;
    exp_err = v.exp_err;
    m_axi_bresp = v.bresp;
    wq.push_back(dat(v.seed, 0));
    while (i < stop_at && g < 2000) begin
      S_WR_tvalid = ($urandom_range(99) >= v.tv_pct);
      S_WR_tdata = dat(v.seed, i);
      S_WR_tlast = (i == v.tlast_beat);
      m_axi_wready = ($urandom_range(99) >= v.wr_pct);
      m_axi_awready = ($urandom_range(99) >= v.aw_pct);
      if (v.drop_en && i == 5) i_wr_en = 1'b0;
      @(negedge clk);
      if (S_WR_tvalid && S_WR_tready) begin
        i++;
        if (i < 16) wq.push_back(dat(v.seed, i));
      end
      @(posedge clk);
      #1;
      g++;
    end
    chk("beat_budget", 64'(i), 64'(stop_at));
    if (stop_at < 16) return;
    S_WR_tvalid = 1'b0;
    S_WR_tlast = 1'b0;
    g = 0;
    while (done_cnt == c0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("done_pulse", 64'(done_cnt), 64'(c0 + 1));
    if (v.drop_en) begin
      repeat (5) begin
        S_WR_tvalid = 1'b1;
        @(negedge clk);
        chk("no_start", 64'(m_axi_awvalid), 64'd0);
        @(posedge clk);
        #1;
      end
      S_WR_tvalid = 1'b0;
      i_wr_en = 1'b1;
    end
  endtask

  initial begin
    vec_t vecs[8];
    vec_t fill;
    int c0;
    vecs[0] = '{0, 0, 0, 2'b00, 15, 64'h0, 1'b0, 1'b0};
    vecs[1] = '{0, 0, 0, 2'b00, 15, 64'h0102030405060708,
                1'b0, 1'b0};
    vecs[2] = '{30, 30, 50, 2'b00, 15, 64'hDEAD_BEEF_0000_1111,
                1'b0, 1'b0};
    vecs[3] = '{50, 40, 0, 2'b00, 15, 64'h1234_5678_9ABC_DEF0,
                1'b0, 1'b0};
    vecs[4] = '{0, 0, 0, 2'b10, 15, 64'hA5A5_0000_5A5A_0000,
                1'b0, 1'b1};
    vecs[5] = '{10, 10, 10, 2'b00, 10, 64'h0F0F_0F0F_0000_0000,
                1'b0, TL_ERR};
    vecs[6] = '{0, 20, 0, 2'b00, 15, 64'h7777_0000_3333_0000,
                1'b1, 1'b0};
    vecs[7] = '{20, 20, 20, 2'b01, 15, 64'h0000_CAFE_0000_F00D,
                1'b0, 1'b1};
    fill = '{15, 15, 15, 2'b00, 15, 64'h5555_0000_AAAA_0000,
             1'b0, 1'b0};

    S_WR_areset = 1'b1;
    i_wr_en = 1'b0;
    S_WR_tdata = '0;
    S_WR_tvalid = 1'b0;
    S_WR_tlast = 1'b0;
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    m_axi_bid = 1'b0;
    m_axi_bresp = 2'b00;
    m_axi_bvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_chk("reset");
    S_WR_areset = 1'b0;
    i_wr_en = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) begin
      run_burst(vecs[k], 16);
      if (k == 0) chk("first_awaddr", 64'(last_awaddr), 64'h0);
      if (k == 1) chk("second_awaddr", 64'(last_awaddr), 64'h1000);
    end
    while (done_cnt < 16) run_burst(fill, 16);
    chk("slot16_awaddr", 64'(last_awaddr), 64'hF000);
    run_burst(fill, 16);
    chk("wrap_awaddr", 64'(last_awaddr), 64'h0);

    run_burst(vecs[0], 7);
    chk("mid_awaddr", 64'(last_awaddr), 64'h1000);
    S_WR_areset = 1'b1;
    #1;
    idle_chk("rst_mid");
    S_WR_tvalid = 1'b0;
    wq.delete();
    c0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    S_WR_areset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_rst", 64'(done_cnt), 64'(c0));
    run_burst(vecs[3], 16);
    chk("post_rst_awaddr", 64'(last_awaddr), 64'h0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
